// File: rtl/mem_bus_ctrl.sv
// CPU-side bus controller: sequences SRAM and memory-mapped UART accesses over
// a shared data bus and stalls the pipeline until each access completes.
module mem_bus_ctrl #(
    parameter int                DW             = 16,
    parameter int                CPU_AW         = 16,
    parameter int                RAM_AW         = 18,
    parameter int                WAIT_CYC       = 1,
    parameter logic [CPU_AW-1:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [CPU_AW-1:0] UART_STAT_ADDR = 16'hBF01,
    parameter bit                UART_TX_WAIT   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [CPU_AW-1:0] addr,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [RAM_AW-1:0] ram_addr,
    inout  wire  [DW-1:0]     ram_data,
    input  logic              tbre,
    input  logic              tsre,
    input  logic              data_ready,
    output logic              rdn,
    output logic              wrn
);

    localparam int CW = $clog2(WAIT_CYC + 2);
    localparam logic [CW-1:0] CNT_ACT = CW'(WAIT_CYC - 1);
    localparam logic [CW-1:0] CNT_URD = CW'(WAIT_CYC);

    typedef enum logic [3:0] {
        IDLE, RD_SETUP, RD_ACT, WR_SETUP, WR_ACT, WR_HOLD,
        URD_WAIT, URD_ACT, UWR_ACT, UWR_WAIT, DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          tbre_seen, tbre_seen_next;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] stat_word;
    logic          sel_data, sel_stat, accept, drive;

    assign sel_data  = (addr == UART_DATA_ADDR);
    assign sel_stat  = (addr == UART_STAT_ADDR);
    assign accept    = (state == IDLE) && (req_rd ^ req_wr);
    assign stat_word = DW'({data_ready, tbre & tsre});

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        tbre_seen_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept && req_rd) begin
                    if (sel_data)      state_next = URD_WAIT;
                    else if (sel_stat) state_next = DONE;
                    else               state_next = RD_SETUP;
                end else if (accept) begin
                    if (sel_data) begin
                        state_next = UWR_ACT;
                        cnt_next   = CNT_ACT;
                    end else if (sel_stat) begin
                        state_next = DONE;
                    end else begin
                        state_next = WR_SETUP;
                    end
                end
            end
            RD_SETUP: begin
                state_next = RD_ACT;
                cnt_next   = CNT_ACT;
            end
            RD_ACT: begin
                if (cnt == '0) state_next = DONE;
                else           cnt_next   = cnt - CW'(1);
            end
            WR_SETUP: begin
                state_next = WR_ACT;
                cnt_next   = CNT_ACT;
            end
            WR_ACT: begin
                if (cnt == '0) state_next = WR_HOLD;
                else           cnt_next   = cnt - CW'(1);
            end
            WR_HOLD: state_next = DONE;
            URD_WAIT: begin
                if (data_ready) begin
                    state_next = URD_ACT;
                    cnt_next   = CNT_URD;
                end
            end
            URD_ACT: begin
                if (cnt == '0) state_next = DONE;
                else           cnt_next   = cnt - CW'(1);
            end
            UWR_ACT: begin
                if (cnt == '0) state_next = UART_TX_WAIT ? UWR_WAIT : DONE;
                else           cnt_next   = cnt - CW'(1);
            end
            // tsre only counts once tbre has already been seen high
            UWR_WAIT: begin
                tbre_seen_next = tbre_seen | tbre;
                if (tbre_seen && tsre) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            tbre_seen <= 1'b0;
            ram_addr  <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            tbre_seen <= tbre_seen_next;
            err       <= (state == IDLE) && req_rd && req_wr;
            if (accept && !sel_data && !sel_stat)
                ram_addr <= RAM_AW'(addr);
            if (accept && req_rd && sel_stat)
                rdata <= stat_word;
            else if (state == RD_ACT && cnt == '0)
                rdata <= ram_data;
            else if (state == URD_ACT && cnt == '0)
                rdata <= DW'(ram_data[7:0]);
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) wdata_q <= wdata;
    end

    // Strobes decode straight from state so reset releases them immediately
    assign busy     = accept || (state != IDLE && state != DONE);
    assign done     = (state == DONE);
    assign ram_en_n = !(state inside {RD_SETUP, RD_ACT, WR_SETUP, WR_ACT, WR_HOLD});
    assign ram_oe_n = (state != RD_ACT);
    assign ram_we_n = (state != WR_ACT);
    assign rdn      = (state != URD_ACT);
    assign wrn      = (state != UWR_ACT);
    assign drive    = state inside {WR_SETUP, WR_ACT, WR_HOLD, UWR_ACT};
    assign ram_data = drive ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: SRAM/UART bus models plus a
// transaction-level reference model driven by directed and random accesses.
module tb_mem_bus_ctrl;

    localparam int          W     = 1;
    localparam logic [15:0] UDATA = 16'hBF00;
    localparam logic [15:0] USTAT = 16'hBF01;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req_rd = 1'b0, req_wr = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic [15:0] rdata;
    logic        busy, done, err;
    logic        ram_en_n, ram_oe_n, ram_we_n;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        tbre = 1'b0, tsre = 1'b0, data_ready = 1'b0;
    logic        rdn, wrn;

    int n_checks = 0;
    int n_errors = 0;
    int overlap_cnt = 0;

    logic [15:0] sram [0:65535];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] written [$];
    logic [15:0] last_rdata = '0;
    logic [7:0]  uart_rx_byte = '0, uart_hi = '0;
    logic [15:0] uart_tx_seen;

    mem_bus_ctrl #(
        .DW(16), .CPU_AW(16), .RAM_AW(18), .WAIT_CYC(W),
        .UART_DATA_ADDR(UDATA), .UART_STAT_ADDR(USTAT), .UART_TX_WAIT(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_addr(ram_addr), .ram_data(ram_data), .tbre(tbre), .tsre(tsre),
        .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
    );

    always #5 CLK = ~CLK;

    // External devices: SRAM answers while enabled and output-enabled, UART while rdn is low
    assign ram_data = (!ram_en_n && !ram_oe_n) ? sram[ram_addr[15:0]] :
                      (!rdn ? {uart_hi, uart_rx_byte} : 16'hzzzz);

    always @(posedge CLK) begin
        if (!ram_en_n && !ram_we_n) sram[ram_addr[15:0]] <= ram_data;
        if (!wrn) uart_tx_seen <= ram_data;
    end

    always @(negedge CLK) begin
        if (!rdn && !wrn) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One CPU access; expectations come from the access-type timing rules.
    task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, input int ready_at,
                          input int tbre_at, input int tsre_at);
        int lat, n_en, n_oe, n_we, n_rdn, n_wrn, busy_bad, addr_bad;
        int exp_lat, exp_en, exp_oe, exp_we, exp_rdn, exp_wrn, r, t1, t2;
        logic [15:0] exp_rdata;
        lat = 0; n_en = 0; n_oe = 0; n_we = 0; n_rdn = 0; n_wrn = 0;
        busy_bad = 0; addr_bad = 0;
        exp_en = 0; exp_oe = 0; exp_we = 0; exp_rdn = 0; exp_wrn = 0;
        exp_lat = 0; exp_rdata = last_rdata;
        if (a == USTAT) begin
            exp_lat   = 1;
            exp_rdata = {14'd0, (ready_at <= 0), (tbre_at <= 0) && (tsre_at <= 0)};
        end else if (a == UDATA && rd) begin
            r         = (ready_at > 1) ? ready_at : 1;
            exp_lat   = r + W + 2;
            exp_rdn   = W + 1;
            exp_rdata = {8'h00, uart_rx_byte};
        end else if (a == UDATA) begin
            t1      = (tbre_at > 1 + W) ? tbre_at : 1 + W;
            t2      = (tsre_at > t1 + 1) ? tsre_at : t1 + 1;
            exp_lat = t2 + 1;
            exp_wrn = W;
        end else if (rd) begin
            exp_lat   = 2 + W;
            exp_en    = 1 + W;
            exp_oe    = W;
            exp_rdata = ref_mem[a];
        end else begin
            exp_lat = 3 + W;
            exp_en  = 2 + W;
            exp_we  = W;
        end

        req_rd = rd; req_wr = wr; addr = a; wdata = d;
        data_ready = (ready_at <= 0); tbre = (tbre_at <= 0); tsre = (tsre_at <= 0);
        #1 chk("busy_at_accept", {31'd0, busy}, 32'd1);
        for (int n = 1; n <= 400 && lat == 0; n++) begin
            @(negedge CLK);
            if (done) begin
                lat = n;
            end else begin
                if (!busy) busy_bad++;
                if (!ram_en_n) begin
                    n_en++;
                    if (ram_addr !== {2'b00, a}) addr_bad++;
                end
                if (!ram_oe_n) n_oe++;
                if (!ram_we_n) n_we++;
                if (!rdn) n_rdn++;
                if (!wrn) n_wrn++;
                data_ready = (n >= ready_at);
                tbre       = (n >= tbre_at);
                tsre       = (n >= tsre_at);
            end
        end
        chk("latency", lat, exp_lat);
        chk("rdata", {16'd0, rdata}, {16'd0, exp_rdata});
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        chk("busy_while_stalled", busy_bad, 0);
        chk("ram_en_low_cycles", n_en, exp_en);
        chk("ram_oe_low_cycles", n_oe, exp_oe);
        chk("ram_we_low_cycles", n_we, exp_we);
        chk("rdn_low_cycles", n_rdn, exp_rdn);
        chk("wrn_low_cycles", n_wrn, exp_wrn);
        chk("ram_addr", addr_bad, 0);
        if (a == UDATA && wr) chk("uart_tx_data", {16'd0, uart_tx_seen}, {16'd0, d});
        if (a != UDATA && a != USTAT && wr) begin
            ref_mem[a] = d;
            written.push_back(a);
        end
        last_rdata = exp_rdata;
        req_rd = 1'b0; req_wr = 1'b0;
        data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
        @(negedge CLK);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic conflict(input logic [15:0] a);
        req_rd = 1'b1; req_wr = 1'b1; addr = a;
        #1 chk("busy_conflict", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("strobes_conflict", {27'd0, ram_en_n, ram_oe_n, ram_we_n, rdn, wrn}, 32'h1F);
        chk("busy_after_conflict", {31'd0, busy}, 32'd0);
        chk("done_conflict", {31'd0, done}, 32'd0);
        req_rd = 1'b0; req_wr = 1'b0;
        @(negedge CLK);
        chk("err_single", {31'd0, err}, 32'd0);
        chk("done_after_conflict", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [15:0] a, d;
        int          op, ra, ta, done_cnt;
        bit          seen_act;

        #2;
        chk("rst_ram_strobes", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'h7);
        chk("rst_uart_strobes", {30'd0, rdn, wrn}, 32'h3);
        chk("rst_ram_addr", {14'd0, ram_addr}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);

        @(negedge CLK);
        RST = 1'b1;
        access(1'b0, 1'b1, 16'h0123, 16'hA5C3, 0, 0, 0);
        access(1'b1, 1'b0, 16'h0123, 16'h0000, 0, 0, 0);
        uart_rx_byte = 8'h5A; uart_hi = 8'hC3;
        access(1'b1, 1'b0, UDATA, 16'h0000, 11, 0, 0);
        access(1'b0, 1'b1, UDATA, 16'h0041, 0, 5, 8);
        conflict(16'h0123);
        access(1'b1, 1'b0, USTAT, 16'h0000, 0, 0, 1000);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            d  = 16'($urandom);
            case (op)
                0: begin
                    a = 16'($urandom);
                    if (a == UDATA || a == USTAT) a = 16'h7FFE;
                    access(1'b0, 1'b1, a, d, 0, 0, 0);
                end
                1: begin
                    a = written[$urandom_range(0, written.size() - 1)];
                    access(1'b1, 1'b0, a, d, 0, 0, 0);
                end
                2: begin
                    ra = $urandom_range(0, 1) ? 0 : 1000;
                    ta = $urandom_range(0, 1) ? 0 : 1000;
                    access(1'b1, 1'b0, USTAT, d, ra, ta, $urandom_range(0, 1) ? 0 : 1000);
                end
                3: begin
                    uart_rx_byte = 8'($urandom);
                    uart_hi      = 8'($urandom);
                    access(1'b1, 1'b0, UDATA, d, $urandom_range(0, 6), 0, 0);
                end
                4: begin
                    ta = $urandom_range(0, 6);
                    access(1'b0, 1'b1, UDATA, d, 0, ta, ta + $urandom_range(1, 4));
                end
                default: conflict(16'($urandom));
            endcase
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        a = written[0];
        req_rd = 1'b1; addr = a;
        seen_act = 1'b0;
        for (int n = 0; n < 10 && !seen_act; n++) begin
            @(negedge CLK);
            if (!ram_oe_n) seen_act = 1'b1;
        end
        chk("reached_rd_act", {31'd0, seen_act}, 32'd1);
        RST = 1'b0;
        #1;
        chk("abort_ram_strobes", {29'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'h7);
        chk("abort_rdata", {16'd0, rdata}, 32'd0);
        chk("abort_ram_addr", {14'd0, ram_addr}, 32'd0);
        req_rd = 1'b0;
        done_cnt = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        RST = 1'b1;
        last_rdata = '0;
        access(1'b1, 1'b0, a, 16'h0000, 0, 0, 0);

        chk("rdn_wrn_never_both_low", overlap_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameters SHALL be:
- DW, 16, data width.
- CPU_AW, 16, CPU address width.
- RAM_AW, 18, SRAM address width, at least CPU_AW.
- WAIT_CYC, 1, strobe-active cycles per access, 1..15.
- UART_DATA_ADDR, 16'hBF00, UART data register.
- UART_STAT_ADDR, 16'hBF01, UART status register.
- UART_TX_WAIT, 1, when 1 a write completes only after transmit finishes.

REQ-002 Ports SHALL be:
- CLK  in  1  clock.
- RST  in  1  reset.
- req_rd  in  1  read request, held by CPU until done.
- req_wr  in  1  write request, held by CPU until done.
- addr  in  CPU_AW  access address.
- wdata  in  DW  write data.
- rdata  out  DW  read data.
- busy  out  1  stall to pipeline.
- done  out  1  access-complete pulse.
- err  out  1  illegal-request pulse.
- ram_en_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes.
- ram_addr  out  RAM_AW  SRAM address.
- ram_data  inout  DW  bus shared by SRAM and UART.
- tbre, tsre, data_ready  in  1 each  UART status.
- rdn, wrn  out  1 each  UART strobes, active-low.

REQ-003 The block SHALL use one clock, CLK; reset SHALL be RST, asynchronous and active-low.

Function
REQ-010 States SHALL be IDLE, RD_SETUP, RD_ACT, WR_SETUP, WR_ACT, WR_HOLD, URD_WAIT, URD_ACT, UWR_ACT, UWR_WAIT and DONE.

REQ-011 Requests SHALL be sampled only in IDLE, and addr and wdata SHALL be latched at acceptance.

REQ-012 If req_rd and req_wr are both 1 in IDLE, the request SHALL be ignored: err=1 for one cycle, the FSM stays in IDLE, and there is no bus activity.

REQ-013 busy SHALL be combinational: 1 when (state==IDLE and exactly one request is asserted) or state is neither IDLE nor DONE; 0 otherwise.

REQ-014 done SHALL be 1 exactly in DONE, which lasts one cycle and then returns to IDLE; rdata SHALL be valid from DONE until the next read capture.

REQ-015 Address decode: addr==UART_DATA_ADDR selects the UART data register, addr==UART_STAT_ADDR selects UART status, and anything else selects SRAM with ram_addr = zero-extended addr.

REQ-016 SRAM read path:
- IDLE -> RD_SETUP: ram_en_n=0, ram_oe_n=1, ram_addr driven.
- RD_ACT: ram_oe_n=0 for WAIT_CYC cycles.
- ram_data SHALL be captured into rdata on the last RD_ACT edge, then -> DONE.
- Acceptance in cycle C0 SHALL give done in cycle C0+2+WAIT_CYC.

REQ-017 SRAM write path:
- WR_SETUP: ram_en_n=0, ram_we_n=1.
- WR_ACT: ram_we_n=0 for WAIT_CYC cycles.
- WR_HOLD: ram_we_n=1.
- Then -> DONE, giving done at C0+3+WAIT_CYC.

REQ-018 ram_data SHALL be driven with the latched wdata only in WR_SETUP, WR_ACT, WR_HOLD and UWR_ACT, and SHALL be high-Z in every other state.

REQ-019 Status read SHALL return rdata = {zeros, data_ready, tbre&tsre}, i.e. bit1=data_ready and bit0=tbre&tsre, with done at C0+1 and no strobes asserted.

REQ-020 UART data read path:
- URD_WAIT SHALL hold until data_ready=1.
- URD_ACT: rdn=0 for WAIT_CYC+1 cycles.
- rdata = zero-extended ram_data[7:0] captured on the last URD_ACT edge, then -> DONE.

REQ-021 UART data write path:
- UWR_ACT: wrn=0 for WAIT_CYC cycles, with data driven.
- If UART_TX_WAIT=1, UWR_WAIT SHALL hold until tbre=1 and then tsre=1, each sampled high; otherwise -> DONE directly.

REQ-022 During any UART state, ram_en_n=1, ram_oe_n=1 and ram_we_n=1.

REQ-023 rdn and wrn SHALL be 1 outside their ACT states, and they SHALL never be 0 simultaneously.

REQ-024 The wait counter SHALL be $clog2(WAIT_CYC+2) bits, SHALL load on ACT entry, and SHALL not wrap.

REQ-025 The UART wait states SHALL have no timeout; the CPU stalls for as long as the UART is not ready.

Reset
REQ-030 While RST=0, outputs SHALL be asynchronously forced to:
- state=IDLE.
- ram_en_n=1, ram_oe_n=1, ram_we_n=1.
- ram_addr=0, rdata=0.
- done=0, err=0.
- rdn=1, wrn=1.
- ram_data high-Z.

REQ-031 Reset asserted mid-access SHALL abort the access without completing any strobe, and SHALL not produce a done.

REQ-032 After RST rises, the first request SHALL be accepted on the first CLK edge.

Verification
REQ-040 With WAIT_CYC=1, SRAM write of 16'hA5C3 to 16'h0123 -> ram_we_n low exactly 1 cycle, ram_addr=18'h00123, done at C0+4, busy=0 only in DONE.

REQ-041 SRAM read back from 16'h0123 -> ram_oe_n low 1 cycle, rdata=16'hA5C3, done at C0+3.

REQ-042 UART read with data_ready=0 for 10 cycles, then bus byte 8'h5A -> rdn stays 1 during the wait, then low for 2 cycles, rdata=16'h005A.

REQ-043 UART write of 16'h0041 with tbre rising 5 cycles later and tsre 3 cycles after that -> wrn low 1 cycle, done exactly 1 cycle after tsre is sampled high.

REQ-044 req_rd=req_wr=1 -> err pulses once, no strobes, busy=0; also status read with data_ready=1, tbre=1, tsre=0 -> rdata=16'h0002.

REQ-045 Assert RST in RD_ACT -> ram_oe_n and ram_en_n go to 1 immediately, done never pulses, and the next read completes normally.
